// File: rtl/usb_rx_if.sv
// usb_rx line-side inputs and protocol-side receive bus.
// slave = receiver, master = line driver / protocol layer.
interface usb_rx_if;
  logic       dataInP;
  logic       dataInN;
  logic       usbResetDetect;
  logic [7:0] rxData;
  logic       rxDataValid;
  logic       rxPacketEnd;
  logic       rxError;
  logic       receiving;

  modport slave (
    input  dataInP, dataInN, usbResetDetect,
    output rxData, rxDataValid, rxPacketEnd,
    output rxError, receiving
  );

  modport master (
    output dataInP, dataInN, usbResetDetect,
    input  rxData, rxDataValid, rxPacketEnd,
    input  rxError, receiving
  );
endinterface

// File: rtl/usb_rx.sv
// Full-speed USB receiver: sync, 4x DPLL, NRZI,
// SYNC/stuff/EOP handling, LSB-first byte assembly.
module usb_rx #(
  parameter int unsigned SAMPLE_PHASE = 2,
  parameter int unsigned SYNC_ZEROS   = 6
) (
  input  logic     clk48,
  input  logic     rst_n,
  usb_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_EOP, S_ERR
  } state_t;

  localparam logic [1:0] L_SE0 = 2'b00;
  localparam logic [1:0] L_J   = 2'b10;
  localparam logic [1:0] LP_PH = SAMPLE_PHASE[1:0];
  localparam logic [3:0] LP_SZ = SYNC_ZEROS[3:0];

  logic       r_p1, r_p2, r_n1, r_n2;
  logic [1:0] w_line;
  logic [1:0] r_line_d;
  logic [1:0] r_phase;
  logic       w_strobe;
  logic       w_se0;
  logic       w_bit;

  state_t     r_state;
  logic [1:0] r_prev;
  logic [3:0] r_zeros;
  logic [2:0] r_ones;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic [1:0] r_se0cnt;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_end;
  logic       r_err;
  logic       r_recv;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_p1 <= 1'b1;
      r_p2 <= 1'b1;
      r_n1 <= 1'b0;
      r_n2 <= 1'b0;
    end else begin
      r_p1 <= bus.dataInP;
      r_p2 <= r_p1;
      r_n1 <= bus.dataInN;
      r_n2 <= r_n1;
    end
  end

  // SE1 folds into SE0 so it never looks like an edge
  assign w_line = (r_p2 ^ r_n2) ? {r_p2, r_n2} : L_SE0;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_line_d <= L_J;
      r_phase  <= 2'd0;
    end else begin
      r_line_d <= w_line;
      r_phase  <= (w_line != r_line_d) ? 2'd0
                                       : r_phase + 2'd1;
    end
  end

  // sample the delayed state so a short bit is not skipped
  assign w_strobe = (r_phase == LP_PH);
  assign w_se0    = (r_line_d == L_SE0);
  assign w_bit    = (r_line_d == r_prev);

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_prev   <= L_J;
      r_zeros  <= 4'd0;
      r_ones   <= 3'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
      r_se0cnt <= 2'd0;
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_end    <= 1'b0;
      r_err    <= 1'b0;
      r_recv   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
      if (bus.usbResetDetect) begin
        r_state  <= S_IDLE;
        r_prev   <= L_J;
        r_zeros  <= 4'd0;
        r_ones   <= 3'd0;
        r_bitcnt <= 3'd0;
        r_shift  <= 8'h00;
        r_se0cnt <= 2'd0;
        r_recv   <= 1'b0;
      end else if (w_strobe) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_se0) begin
              r_zeros <= 4'd0;
              r_prev  <= L_J;
            end else begin
              r_prev <= r_line_d;
              if (!w_bit) begin
                if (r_zeros != 4'hF)
                  r_zeros <= r_zeros + 4'd1;
              end else begin
                r_zeros <= 4'd0;
                if (r_zeros >= LP_SZ) begin
                  r_state  <= S_DATA;
                  r_recv   <= 1'b1;
                  r_bitcnt <= 3'd0;
                  r_ones   <= 3'd1;
                end
              end
            end
          end
          S_DATA: begin
            if (w_se0) begin
              r_state  <= S_EOP;
              r_se0cnt <= 2'd1;
            end else begin
              r_prev <= r_line_d;
              if (r_ones == 3'd6) begin
                r_ones <= 3'd0;
                if (w_bit) begin
                  r_state  <= S_ERR;
                  r_end    <= 1'b1;
                  r_err    <= 1'b1;
                  r_recv   <= 1'b0;
                  r_se0cnt <= 2'd0;
                end
              end else begin
                r_ones   <= w_bit ? r_ones + 3'd1 : 3'd0;
                r_shift  <= {w_bit, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                  r_data  <= {w_bit, r_shift[7:1]};
                  r_valid <= 1'b1;
                end
              end
            end
          end
          S_EOP: begin
            if (w_se0) begin
              if (r_se0cnt != 2'd2)
                r_se0cnt <= r_se0cnt + 2'd1;
            end else begin
              r_state <= S_IDLE;
              r_end   <= 1'b1;
              r_err   <= (r_line_d != L_J) ||
                         (r_bitcnt != 3'd0) ||
                         (r_se0cnt != 2'd2);
              r_recv  <= 1'b0;
              r_prev  <= L_J;
              r_zeros <= 4'd0;
            end
          end
          S_ERR: begin
            // r_se0cnt doubles as "SE0 seen" while draining
            if (w_se0) begin
              r_se0cnt <= 2'd1;
            end else if (r_se0cnt != 2'd0 &&
                         r_line_d == L_J) begin
              r_state  <= S_IDLE;
              r_prev   <= L_J;
              r_zeros  <= 4'd0;
              r_se0cnt <= 2'd0;
            end else begin
              r_se0cnt <= 2'd0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rxData      = r_data;
  assign bus.rxDataValid = r_valid;
  assign bus.rxPacketEnd = r_end;
  assign bus.rxError     = r_err;
  assign bus.receiving   = r_recv;

endmodule

// File: tb/tb_usb_rx.sv
// Self-checking bench for usb_rx: NRZI/stuffing encoder
// drives the line, scoreboard queue checks received events.
module tb_usb_rx;

  typedef struct packed {
    logic       is_end;
    logic [7:0] val;
  } ev_t;

  logic clk48 = 1'b0;
  logic rst_n = 1'b1;
  usb_rx_if u_if ();

  usb_rx #(.SAMPLE_PHASE(2), .SYNC_ZEROS(6)) dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk48 = ~clk48;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_events = 0;
  ev_t  q[$];
  ev_t  m_exp, m_got;
  logic lvl_j = 1'b1;
  int   ones  = 0;
  bit   jit   = 1'b0;
  bit   ph    = 1'b0;

  always @(negedge clk48) begin
    if (u_if.rxDataValid === 1'b1 ||
        u_if.rxPacketEnd === 1'b1) begin
      n_events++;
      n_checks++;
      m_got = u_if.rxPacketEnd ?
              {1'b1, 7'b0, u_if.rxError} :
              {1'b0, u_if.rxData};
      if (u_if.rxDataValid && u_if.rxPacketEnd) begin
        n_errors++;
        $display("FAIL both_strobes valid=1 end=1 required one");
      end else if (q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event got=%03h required none",
                 m_got);
      end else begin
        m_exp = q.pop_front();
        if (m_got !== m_exp) begin
          n_errors++;
          $display("FAIL event got=%03h required=%03h",
                   m_got, m_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drv(input logic p, input logic n,
                     input int c);
    u_if.dataInP = p;
    u_if.dataInN = n;
    repeat (c) begin
      @(posedge clk48);
      #1;
    end
  endtask

  task automatic tx_raw(input bit b);
    int c;
    if (!b) lvl_j = ~lvl_j;
    if (jit) begin
      c  = ph ? 5 : 3;
      ph = ~ph;
    end else begin
      c = 4;
    end
    drv(lvl_j, ~lvl_j, c);
  endtask

  task automatic tx_bit(input bit b);
    tx_raw(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      tx_raw(1'b0);
      ones = 0;
    end
  endtask

  task automatic tx_sync();
    lvl_j = 1'b1;
    repeat (7) tx_raw(1'b0);
    tx_raw(1'b1);
    ones = 1;
  endtask

  task automatic tx_byte(input logic [7:0] v);
    logic [7:0] b;
    b = v;
    q.push_back({1'b0, v});
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
  endtask

  task automatic tx_eop(input bit expect_end,
                        input bit err);
    if (expect_end) q.push_back({1'b1, 7'b0, err});
    drv(1'b0, 1'b0, 8);
    lvl_j = 1'b1;
    drv(1'b1, 1'b0, 12);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && q.size() != 0; i++)
      @(posedge clk48);
    #1;
  endtask

  task automatic test_reset();
    u_if.usbResetDetect = 1'b0;
    drv(1'b1, 1'b0, 1);
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++)
      drv(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1);
    n_checks += 5;
    if (u_if.rxData !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_rxData got=%02h required=00",
               u_if.rxData);
    end
    if (u_if.rxDataValid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_valid got=%b required=0",
               u_if.rxDataValid);
    end
    if (u_if.rxPacketEnd !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_end got=%b required=0",
               u_if.rxPacketEnd);
    end
    if (u_if.rxError !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_error got=%b required=0",
               u_if.rxError);
    end
    if (u_if.receiving !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_receiving got=%b required=0",
               u_if.receiving);
    end
    drv(1'b1, 1'b0, 4);
    rst_n = 1'b1;
    drv(1'b1, 1'b0, 60);
    n_checks++;
    if (n_events !== 0 || u_if.receiving !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_quiet events=%0d recv=%b required 0 0",
               n_events, u_if.receiving);
    end
  endtask

  task automatic test_ack();
    tx_sync();
    tx_byte(8'hD2);
    n_checks++;
    if (u_if.receiving !== 1'b1) begin
      n_errors++;
      $display("FAIL ack_receiving got=%b required=1",
               u_if.receiving);
    end
    tx_eop(1'b1, 1'b0);
    wait_drain();
    n_checks += 3;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL ack_drain left=%0d required=0", q.size());
      q.delete();
    end
    if (u_if.rxData !== 8'hD2) begin
      n_errors++;
      $display("FAIL ack_hold got=%02h required=d2",
               u_if.rxData);
    end
    if (u_if.receiving !== 1'b0) begin
      n_errors++;
      $display("FAIL ack_recv_end got=%b required=0",
               u_if.receiving);
    end
  endtask

  task automatic test_stuffing();
    tx_sync();
    tx_byte(8'hC3);
    tx_byte(8'hFF);
    tx_byte(8'hFF);
    tx_eop(1'b1, 1'b0);
    wait_drain();
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL stuff_drain left=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic test_stuff_error();
    tx_sync();
    q.push_back({1'b1, 7'b0, 1'b1});
    repeat (7) tx_raw(1'b1);
    n_checks++;
    if (u_if.receiving !== 1'b0) begin
      n_errors++;
      $display("FAIL stuff_err_recv got=%b required=0",
               u_if.receiving);
    end
    tx_eop(1'b0, 1'b0);
    wait_drain();
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL stuff_err_drain left=%0d required=0",
               q.size());
      q.delete();
    end
    test_ack();
  endtask

  task automatic test_jitter_partial();
    jit = 1'b1;
    ph  = 1'b0;
    tx_sync();
    tx_byte(8'hD2);
    jit = 1'b0;
    tx_eop(1'b1, 1'b0);
    wait_drain();
    tx_sync();
    tx_byte(8'hA5);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_eop(1'b1, 1'b1);
    wait_drain();
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL jit_part_drain left=%0d required=0",
               q.size());
      q.delete();
    end
  endtask

  task automatic test_abort();
    int ev0;
    ev0 = n_events;
    tx_sync();
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b0);
    n_checks++;
    if (u_if.receiving !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_pre_recv got=%b required=1",
               u_if.receiving);
    end
    u_if.usbResetDetect = 1'b1;
    @(posedge clk48);
    #1;
    u_if.usbResetDetect = 1'b0;
    n_checks++;
    if (u_if.receiving !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_recv got=%b required=0",
               u_if.receiving);
    end
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b1);
    tx_eop(1'b0, 1'b0);
    n_checks++;
    if (n_events !== ev0) begin
      n_errors++;
      $display("FAIL abort_events got=%0d required=%0d",
               n_events - ev0, 0);
    end
    test_ack();
  endtask

  task automatic test_mid_reset();
    tx_sync();
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (u_if.receiving !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_recv got=%b required=0",
               u_if.receiving);
    end
    if (u_if.rxData !== 8'h00) begin
      n_errors++;
      $display("FAIL midrst_data got=%02h required=00",
               u_if.rxData);
    end
    lvl_j = 1'b1;
    drv(1'b1, 1'b0, 4);
    rst_n = 1'b1;
    drv(1'b1, 1'b0, 12);
    test_ack();
  endtask

  initial begin
    u_if.dataInP        = 1'b1;
    u_if.dataInN        = 1'b0;
    u_if.usbResetDetect = 1'b0;
    #2;
    test_reset();
    test_ack();
    test_stuffing();
    test_stuff_error();
    test_jitter_partial();
    test_abort();
    test_mid_reset();
    drv(1'b1, 1'b0, 20);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL final_queue left=%0d required=0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule
